nn_layer_sequencer: RTL

- Control-only scheduler for the two-layer MLP forward pass (N_IN→N_HID with ReLU, then N_HID→N_OUT).
- Drives one shared external MAC datapath and its synchronous memories: weight ROM (flat, row-major), activation source (input pixels or hidden buffer), bias ROM (b1 followed by b2).
- Issues one read per cycle, aligns the MAC strobes to memory latency, and commits each neuron result to the hidden buffer or the output register file.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/nn_layer_sequencer_if.sv | 41 ++++
 rtl/nn_rd_delay.sv | 34 +++
 rtl/nn_layer_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the two-layer MLP sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

    localparam int N_IN  = 784;
    localparam int N_HID = 10;
    localparam int N_OUT = 10;
    localparam int DW    = 16;

    // Address widths: weights cover both layers, biases hold b1 then b2.
    localparam int W_AW = $clog2(N_IN * N_HID + N_HID * N_OUT);
    localparam int A_AW = $clog2(N_IN);
    localparam int B_AW = $clog2(N_HID + N_OUT);
    localparam int N_AW = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BIAS  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    typedef enum logic {
        LAYER1 = 1'b0,
        LAYER2 = 1'b1
    } layer_t;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control bundle between the layer sequencer and the MAC datapath/memories.
// Latency: n/a (wires only).
// Backpressure: none; the datapath consumes every strobe in the cycle it is issued.
// Ports: master = sequencer side (drives strobes/addresses, receives start/abort/acc_data);
//        slave  = datapath/controller side.
interface nn_layer_sequencer_if;
    import nn_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   rd_en;
    logic [W_AW-1:0]        w_addr;
    logic                   act_sel;
    logic [A_AW-1:0]        act_addr;
    logic                   b_rd;
    logic [B_AW-1:0]        b_addr;
    logic                   mac_en;
    logic                   mac_first;
    logic                   bias_en;
    logic                   wr_en;
    logic                   relu_en;
    logic                   wr_sel;
    logic [N_AW-1:0]        wr_addr;
    logic signed [DW-1:0]   acc_data;
    logic [N_AW-1:0]        pred_class;

    modport master (
        input  start, abort, acc_data,
        output busy, done, rd_en, w_addr, act_sel, act_addr, b_rd, b_addr,
               mac_en, mac_first, bias_en, wr_en, relu_en, wr_sel, wr_addr, pred_class
    );

    modport slave (
        output start, abort, acc_data,
        input  busy, done, rd_en, w_addr, act_sel, act_addr, b_rd, b_addr,
               mac_en, mac_first, bias_en, wr_en, relu_en, wr_sel, wr_addr, pred_class
    );

endinterface

// File: rtl/nn_rd_delay.sv
// Delays the per-read tags {mac, first, bias} to line up with memory read data.
// Latency: exactly LAT cycles.
// Backpressure: none; i_flush empties every stage on the next edge.
// Ports: clk, rst_n, i_flush, i_mac/i_first/i_bias in; o_mac/o_first/o_bias out.
module nn_rd_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_mac,
    input  logic i_first,
    input  logic i_bias,
    output logic o_mac,
    output logic o_first,
    output logic o_bias
);

    logic [2:0] r_pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {i_mac, i_first, i_bias};
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {o_mac, o_first, o_bias} = r_pipe[LAT-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Schedules the two-layer MLP forward pass on one shared MAC: one read per cycle,
// MAC strobes aligned to MEM_LAT, one commit per neuron.
// Latency: start-to-done N_HID*(N_IN+MEM_LAT+2)+N_OUT*(N_HID+MEM_LAT+2)+1 cycles.
// Backpressure: none; start ignored while busy, abort returns to IDLE next cycle.
// Ports: clk, rst_n (async active-low), bus (nn_layer_sequencer_if.master).
// Optional: define NN_SEQ_ARGMAX_EN to build the running argmax feeding pred_class.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nn_layer_sequencer_if.master  bus
);

    localparam int DC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    seq_state_t         r_state;
    layer_t             r_layer;
    logic [N_AW-1:0]    r_j;
    logic [A_AW-1:0]    r_k;
    logic [DC_W-1:0]    r_dcnt;

    logic w_issue, w_bias, w_write, w_l2;
    logic w_k_last, w_j_last, w_d_last;
    logic [W_AW-1:0] w_kw, w_jw, w_waddr;

    assign w_issue = (r_state == ISSUE);
    assign w_bias  = (r_state == BIAS);
    assign w_write = (r_state == WRITE);
    assign w_l2    = (r_layer == LAYER2);

    assign w_k_last = w_l2 ? (r_k == A_AW'(N_HID - 1)) : (r_k == A_AW'(N_IN - 1));
    assign w_j_last = w_l2 ? (r_j == N_AW'(N_OUT - 1)) : (r_j == N_AW'(N_HID - 1));
    assign w_d_last = (r_dcnt == DC_W'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_layer <= LAYER1;
            r_j     <= '0;
            r_k     <= '0;
            r_dcnt  <= '0;
        end else if (bus.abort) begin
            // Also covers start+abort together in IDLE: the start is dropped.
            r_state <= IDLE;
            r_layer <= LAYER1;
            r_j     <= '0;
            r_k     <= '0;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ISSUE;
                        r_layer <= LAYER1;
                        r_j     <= '0;
                        r_k     <= '0;
                    end
                end
                ISSUE: begin
                    if (w_k_last) r_state <= BIAS;
                    else          r_k     <= r_k + A_AW'(1);
                end
                BIAS: begin
                    r_state <= DRAIN;
                    r_dcnt  <= '0;
                end
                DRAIN: begin
                    // The bias tag leaves the delay line in the last DRAIN cycle.
                    if (w_d_last) r_state <= WRITE;
                    else          r_dcnt  <= r_dcnt + DC_W'(1);
                end
                WRITE: begin
                    r_k <= '0;
                    if (!w_j_last) begin
                        r_j     <= r_j + N_AW'(1);
                        r_state <= ISSUE;
                    end else if (!w_l2) begin
                        // Hidden buffer is complete; layer 2 may now read it.
                        r_layer <= LAYER2;
                        r_j     <= '0;
                        r_state <= ISSUE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Weight ROM is row-major over k: layer 2 rows start after all layer-1 rows.
    assign w_kw    = W_AW'(r_k);
    assign w_jw    = W_AW'(r_j);
    assign w_waddr = w_l2 ? (W_AW'(N_IN * N_HID) + w_kw * W_AW'(N_OUT) + w_jw)
                          : (w_kw * W_AW'(N_HID) + w_jw);

    assign bus.busy     = (r_state != IDLE) && (r_state != DONE);
    assign bus.done     = (r_state == DONE);
    assign bus.rd_en    = w_issue || w_bias;
    assign bus.w_addr   = w_issue ? w_waddr : '0;
    assign bus.act_sel  = w_issue && w_l2;
    assign bus.act_addr = w_issue ? r_k : '0;
    assign bus.b_rd     = w_bias;
    assign bus.b_addr   = !w_bias ? '0 : (w_l2 ? B_AW'(N_HID) + B_AW'(r_j) : B_AW'(r_j));
    assign bus.wr_en    = w_write;
    assign bus.relu_en  = w_write && !w_l2;
    assign bus.wr_sel   = w_write && w_l2;
    assign bus.wr_addr  = w_write ? r_j : '0;

    nn_rd_delay #(.LAT(MEM_LAT)) u_rd_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.abort),
        .i_mac   (w_issue),
        .i_first (w_issue && (r_k == '0)),
        .i_bias  (w_bias),
        .o_mac   (bus.mac_en),
        .o_first (bus.mac_first),
        .o_bias  (bus.bias_en)
    );

`ifdef NN_SEQ_ARGMAX_EN
    logic signed [DW-1:0] r_max;
    logic [N_AW-1:0]      r_arg;
    logic [N_AW-1:0]      r_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max  <= '0;
            r_arg  <= '0;
            r_pred <= '0;
        end else begin
            // Strictly-greater update keeps the lower index on ties; output 0 always loads.
            if (w_write && w_l2 && ((r_j == '0) || (bus.acc_data > r_max))) begin
                r_max <= bus.acc_data;
                r_arg <= r_j;
            end
            if (r_state == DONE) r_pred <= r_arg;
        end
    end

    assign bus.pred_class = r_pred;
`else
    logic w_unused_acc;
    assign w_unused_acc   = ^bus.acc_data;
    assign bus.pred_class = '0;
`endif

endmodule
